narrow_saturate_r0: RTL and testbench
=====================================

Name: narrow_saturate_r0

Overview:
Reverse of the datapath sign/zero extender. It narrows DEPTH packed lanes from BIT_WIDTH_IN to BIT_WIDTH_OUT bits, in signed or unsigned mode, with selectable saturation or wrap. It has a DELAY-stage valid/ready pipeline with backpressure, a per-lane overflow flag, and a sticky saturating overflow-event counter. It feeds narrow store and halfword datapaths.

Parameters:
BIT_WIDTH_IN, 32, input lane width (> BIT_WIDTH_OUT)
BIT_WIDTH_OUT, 16, output lane width (>= 2)
DEPTH, 1, number of packed lanes, 1..8
DELAY, 2, pipeline register stages from input to output, 1..8
CNT_WIDTH, 16, width of overflow-event counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
is_signed  input  1  1 = two's-complement narrowing, 0 = unsigned; sampled with data on accept
saturate  input  1  1 = clamp on overflow, 0 = wrap (keep low bits); sampled on accept
valid_in  input  1  input word valid
ready_in  output  1  block can accept this cycle
dataIn  input  BIT_WIDTH_IN*DEPTH  packed lanes; lane k = bits [IN*k+IN-1 : IN*k]
valid_out  output  1  output word valid
ready_out  input  1  downstream accepts
dataOut  output  BIT_WIDTH_OUT*DEPTH  packed narrowed lanes, same packing rule
ovf_out  output  DEPTH  per-lane overflow flag aligned with dataOut
ovf_count  output  CNT_WIDTH  count of delivered words with any lane overflow
ovf_clear  input  1  synchronous clear of ovf_count

Behaviour:
- Reset (rst=0, async): all stage valids = 0, all stage data and flags = 0, ovf_count = 0. While in reset: valid_out = 0, dataOut = 0, ovf_out = 0, ready_in = 0. On rst deassertion, ready_in = 1 in the first cycle.
- Reset mid-operation discards all in-flight words. Nothing is replayed.
- Pipeline: DELAY register stages moved by a single global enable, advance = !valid_out | ready_out.
  - ready_in = advance (combinational).
  - Accept = valid_in & ready_in.
  - On advance, every stage shifts one place. Stage 0 loads the computed lanes and valid = accept.
  - Bubbles propagate as valid = 0.
- Latency: with ready_out held at 1, a word accepted at edge N appears on valid_out/dataOut after edge N+DELAY-1, i.e. DELAY cycles after presentation. Throughput is 1 word/cycle.
- Stall: valid_out=1 & ready_out=0 freezes every stage. dataOut and ovf_out stay stable. ready_in = 0.
- Lane overflow condition, computed in stage 0 from the sampled mode bits:
  - Signed: bits [IN-1 : OUT-1] of the lane are not all equal.
  - Unsigned: bits [IN-1 : OUT] of the lane are not all zero.
- Lane result:
  - No overflow: low OUT bits.
  - Overflow and saturate=0: low OUT bits; ovf still set.
  - Overflow, saturate=1, signed: positive input gives 0111..1; negative input (MSB=1) gives 1000..0.
  - Overflow, saturate=1, unsigned: all ones.
- Lanes are independent. ovf_out[k] corresponds to lane k.
- ovf_count:
  - Increments by 1 on an output handshake (valid_out & ready_out) where |ovf_out = 1.
  - Saturates at all ones; no wrap.
  - ovf_clear=1 forces 0 at the edge and has priority over a same-cycle increment.
- Mode inputs change freely between words. Each word uses the mode values present on its accept cycle.

Test Plan:
- Reset/idle: hold rst=0, drive valid_in=1 → valid_out=0, dataOut=0, ovf_count=0, ready_in=0. Release rst → ready_in=1 in the first cycle.
- Unsigned, DELAY=2, ready_out=1:
  - 0x0000FFFF → dataOut=0xFFFF, ovf=0, valid_out exactly 2 cycles after accept.
  - 0x00010000, saturate=1 → 0xFFFF, ovf=1.
  - Same input, saturate=0 → 0x0000, ovf=1.
- Signed:
  - 0xFFFF8000 → 0x8000, ovf=0.
  - 0x00008000, saturate=1 → 0x7FFF, ovf=1.
  - 0xFFFF7FFF, saturate=1 → 0x8000, ovf=1.
  - 0xFFFF7FFF, saturate=0 → 0x7FFF, ovf=1.
- Exhaustive: sweep all 2^16 signed and all 2^16 unsigned in-range values → output equals the low 16 bits, ovf=0, no errors.
- Backpressure: stream 10 words while ready_out toggles 1,0,0,1,... → all 10 words delivered in order, none lost or duplicated, dataOut stable while stalled, ready_in low during stall.
- Counter: DEPTH=2 with lanes {0x00000001, 0x00020000} unsigned → ovf_out=2'b10, ovf_count +1. With CNT_WIDTH=4, 20 overflowing words → ovf_count=15. ovf_clear asserted in the same cycle as an overflow handshake → 0. Reset asserted mid-stream → valid_out drops immediately and count=0.

Source files
------------

// File: rtl/narrow_saturate_r0.sv
// narrow_saturate_r0: narrows DEPTH packed lanes from BIT_WIDTH_IN to
// BIT_WIDTH_OUT bits (signed/unsigned, saturate/wrap) through a DELAY-stage
// valid/ready pipeline, with per-lane overflow flags and a sticky
// saturating overflow-event counter.

// Per-lane narrowing: overflow detect plus clamp/wrap result selection.
module narrow_saturate_r0_lane #(
  parameter int BIT_WIDTH_IN  = 32,
  parameter int BIT_WIDTH_OUT = 16
) (
  input  logic [BIT_WIDTH_IN-1:0]  laneIn,
  input  logic                     isSigned,
  input  logic                     saturate,
  output logic [BIT_WIDTH_OUT-1:0] laneOut,
  output logic                     ovf
);
  localparam int IN  = BIT_WIDTH_IN;
  localparam int OUT = BIT_WIDTH_OUT;

  // Signed range holds only when the dropped bits all copy the new sign bit;
  // unsigned range holds only when the dropped bits are all zero.
  logic [IN-OUT:0]   sHi;
  logic [IN-OUT-1:0] uHi;
  assign sHi = laneIn[IN-1:OUT-1];
  assign uHi = laneIn[IN-1:OUT];

  // Overflow detect and result select (wrap keeps the low bits).
  always_comb begin
    ovf     = isSigned ? !((sHi == '0) || (sHi == '1)) : (|uHi);
    laneOut = laneIn[OUT-1:0];
    if (ovf && saturate) begin
      if (!isSigned)          laneOut = '1;
      else if (laneIn[IN-1])  laneOut = {1'b1, {(OUT-1){1'b0}}};
      else                    laneOut = {1'b0, {(OUT-1){1'b1}}};
    end
  end
endmodule

module narrow_saturate_r0 #(
  parameter int BIT_WIDTH_IN  = 32,
  parameter int BIT_WIDTH_OUT = 16,
  parameter int DEPTH         = 1,
  parameter int DELAY         = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             is_signed,
  input  logic                             saturate,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [BIT_WIDTH_IN*DEPTH-1:0]    dataIn,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic [BIT_WIDTH_OUT*DEPTH-1:0]   dataOut,
  output logic [DEPTH-1:0]                 ovf_out,
  output logic [CNT_WIDTH-1:0]             ovf_count,
  input  logic                             ovf_clear
);
  typedef struct packed {
    logic [DEPTH-1:0][BIT_WIDTH_OUT-1:0] data;
    logic [DEPTH-1:0]                    ovf;
  } stage_t;

  logic [DEPTH-1:0][BIT_WIDTH_IN-1:0] laneIn;
  stage_t                             stgNext;
  stage_t [DELAY-1:0]                 stgPipe;
  logic   [DELAY-1:0]                 vldPipe;
  logic                               advance;
  logic                               accept;

  assign laneIn = dataIn;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gLane
      narrow_saturate_r0_lane #(
        .BIT_WIDTH_IN (BIT_WIDTH_IN),
        .BIT_WIDTH_OUT(BIT_WIDTH_OUT)
      ) uLane (
        .laneIn  (laneIn[g]),
        .isSigned(is_signed),
        .saturate(saturate),
        .laneOut (stgNext.data[g]),
        .ovf     (stgNext.ovf[g])
      );
    end
  endgenerate

  // One global enable: the whole pipe moves unless the output is stalled.
  // ready_in is held low while reset is asserted.
  assign advance  = !valid_out || ready_out;
  assign ready_in = rst && advance;
  assign accept   = valid_in && ready_in;

  // Pipeline shift: stage 0 takes the freshly narrowed word, bubbles carry valid=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vldPipe <= '0;
      stgPipe <= '0;
    end else if (advance) begin
      vldPipe[0] <= accept;
      stgPipe[0] <= stgNext;
      for (int i = 1; i < DELAY; i++) begin
        vldPipe[i] <= vldPipe[i-1];
        stgPipe[i] <= stgPipe[i-1];
      end
    end
  end

  assign valid_out = vldPipe[DELAY-1];
  assign dataOut   = stgPipe[DELAY-1].data;
  assign ovf_out   = stgPipe[DELAY-1].ovf;

  // Overflow-event counter: counts delivered words with any lane overflow,
  // sticks at all ones, clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= '0;
    end else if (valid_out && ready_out && (|ovf_out) && (ovf_count != '1)) begin
      ovf_count <= ovf_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_narrow_saturate_r0.sv
// Bench for narrow_saturate_r0 (IN=32, OUT=16, DEPTH=2, DELAY=2, CNT_WIDTH=4):
// directed words with literal expectations, plus an arithmetic model and
// scoreboard checked on every negedge.
module tb_narrow_saturate_r0;
  localparam int IN = 32, OUT = 16, DEPTH = 2, DELAY = 2, CW = 4;

  logic                   clk = 0;
  logic                   rst = 0;
  logic                   is_signed = 0, saturate = 0, valid_in = 0;
  logic                   ready_in;
  logic [IN*DEPTH-1:0]    dataIn = '0;
  logic                   valid_out;
  logic                   ready_out = 1;
  logic [OUT*DEPTH-1:0]   dataOut;
  logic [DEPTH-1:0]       ovf_out;
  logic [CW-1:0]          ovf_count;
  logic                   ovf_clear = 0;

  narrow_saturate_r0 #(
    .BIT_WIDTH_IN(IN), .BIT_WIDTH_OUT(OUT), .DEPTH(DEPTH),
    .DELAY(DELAY), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .is_signed(is_signed), .saturate(saturate),
    .valid_in(valid_in), .ready_in(ready_in), .dataIn(dataIn),
    .valid_out(valid_out), .ready_out(ready_out), .dataOut(dataOut),
    .ovf_out(ovf_out), .ovf_count(ovf_count), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int nDeliv = 0, nStall = 0;
  int expCnt = 0;

  typedef struct packed {
    logic [DEPTH-1:0][OUT-1:0] d;
    logic [DEPTH-1:0]          o;
  } exp_t;
  exp_t q[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Narrowing by value range: the lane is read as an integer and compared
  // against the representable output range.
  function automatic void modelLane(input logic [31:0] v, input bit sg, input bit sat,
                                    output logic [15:0] o, output bit f);
    longint x;
    x = sg ? longint'($signed(v)) : longint'(v);
    o = v[15:0];
    if (sg) begin
      f = (x > 32767) || (x < -32768);
      if (f && sat) o = (x > 0) ? 16'h7FFF : 16'h8000;
    end else begin
      f = (x > 65535);
      if (f && sat) o = 16'hFFFF;
    end
  endfunction

  function automatic exp_t modelWord(logic [63:0] d, bit sg, bit sat);
    exp_t e;
    logic [15:0] o;
    bit f;
    e = '0;
    for (int k = 0; k < DEPTH; k++) begin
      modelLane(d[32*k +: 32], sg, sat, o, f);
      e.d[k] = o;
      e.o[k] = f;
    end
    return e;
  endfunction

  // Scoreboard and counter model, sampled mid-cycle.
  always @(negedge clk) begin
    bit hs, anyOvf;
    hs = 0; anyOvf = 0;
    if (!rst) begin
      chk("rst_valid_out", valid_out, 0);
      chk("rst_dataOut", dataOut, 0);
      chk("rst_ovf_out", ovf_out, 0);
      chk("rst_ready_in", ready_in, 0);
      chk("rst_ovf_count", ovf_count, 0);
      q.delete();
      expCnt = 0;
    end else begin
      chk("ready_in", ready_in, (!valid_out || ready_out));
      chk("ovf_count", ovf_count, expCnt);
      if (valid_out) begin
        if (q.size() == 0) chk("spurious_valid", valid_out, 0);
        else begin
          chk("dataOut", dataOut, q[0].d);
          chk("ovf_out", ovf_out, q[0].o);
        end
        if (!ready_out) nStall++;
      end
      if (valid_out && ready_out && q.size() > 0) begin
        hs = 1; anyOvf = |q[0].o;
        void'(q.pop_front());
        nDeliv++;
      end
      if (ovf_clear) expCnt = 0;
      else if (hs && anyOvf && expCnt != (1 << CW) - 1) expCnt++;
      if (valid_in && ready_in) q.push_back(modelWord(dataIn, is_signed, saturate));
    end
  end

  // Backpressure pattern 1,0,0 on ready_out when enabled.
  bit bpEn = 0;
  int bpPh = 0;
  always @(posedge clk) begin
    #1;
    if (bpEn) begin
      ready_out = (bpPh == 0);
      bpPh = (bpPh + 1) % 3;
    end
  end

  // Single word into an idle pipe; checks latency and literal result.
  task automatic sendOne(string nm, logic [63:0] v, bit sg, bit sat,
                         logic [31:0] ed, logic [1:0] eo);
    dataIn = v; is_signed = sg; saturate = sat; valid_in = 1;
    @(posedge clk); #1 valid_in = 0;
    chk({nm, "_early"}, valid_out, 0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, valid_out, 1);
    chk({nm, "_data"}, dataOut, ed);
    chk({nm, "_ovf"}, ovf_out, eo);
    @(posedge clk); #1;
  endtask

  // Streams one word, holding it until accepted (bounded).
  task automatic pushWord(logic [63:0] v, bit sg, bit sat);
    bit acc;
    acc = 0;
    dataIn = v; is_signed = sg; saturate = sat; valid_in = 1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk); acc = ready_in;
      @(posedge clk); #1;
    end
    valid_in = 0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic pulseClear();
    ovf_clear = 1; @(posedge clk); #1 ovf_clear = 0;
  endtask

  initial begin
    int d0;
    // Reset held with valid_in asserted.
    valid_in = 1; dataIn = 64'h0001_0000_0001_0000;
    repeat (3) @(posedge clk);
    #1 rst = 1; valid_in = 0;
    #1 chk("ready_after_rst", ready_in, 1);
    @(posedge clk); #1;

    // Unsigned directed.
    sendOne("u_ffff",   64'h0000_0000_0000_FFFF, 0, 1, 32'h0000_FFFF, 2'b00);
    sendOne("u_sat",    64'h0000_0000_0001_0000, 0, 1, 32'h0000_FFFF, 2'b01);
    sendOne("u_wrap",   64'h0000_0000_0001_0000, 0, 0, 32'h0000_0000, 2'b01);
    // Signed directed.
    sendOne("s_8000",   64'h0000_0000_FFFF_8000, 1, 1, 32'h0000_8000, 2'b00);
    sendOne("s_satpos", 64'h0000_0000_0000_8000, 1, 1, 32'h0000_7FFF, 2'b01);
    sendOne("s_satneg", 64'h0000_0000_FFFF_7FFF, 1, 1, 32'h0000_8000, 2'b01);
    sendOne("s_wrap",   64'h0000_0000_FFFF_7FFF, 1, 0, 32'h0000_7FFF, 2'b01);
    chk("cnt_directed", ovf_count, 5);

    // In-range sweep: both lanes used, every value covered once per mode.
    for (int v = 0; v < 65536; v += 2) begin
      d0 = v - 32768;
      pushWord({32'(d0 + 1), 32'(d0)}, 1, v[1]);
    end
    for (int v = 0; v < 65536; v += 2) pushWord({32'(v + 1), 32'(v)}, 0, v[1]);
    drain();

    // Backpressure stream of 10 words.
    d0 = nDeliv;
    bpEn = 1;
    for (int i = 0; i < 10; i++)
      pushWord({32'h0000_1000 * i, 32'h0000_8000 + 32'h0001_1111 * i}, i[0], i[1]);
    drain();
    bpEn = 0; ready_out = 1;
    @(posedge clk); #1;
    chk("bp_delivered", nDeliv - d0, 10);
    chk("bp_stalled", (nStall > 0), 1);

    // Counter: per-lane flag on lane 1 only.
    pulseClear();
    sendOne("lane_ovf", 64'h0002_0000_0000_0001, 0, 0, 32'h0000_0001, 2'b10);
    chk("cnt_one", ovf_count, 1);
    for (int i = 0; i < 20; i++) pushWord(64'h0000_0000_0003_0000, 0, 1);
    drain();
    @(posedge clk); #1;
    chk("cnt_sat", ovf_count, 15);
    pulseClear();
    chk("cnt_cleared", ovf_count, 0);
    sendOne("ov_a", 64'h0, 0, 0, 32'h0, 2'b00);
    sendOne("ov_b", 64'h0000_0000_0004_0000, 0, 1, 32'h0000_FFFF, 2'b01);
    sendOne("ov_c", 64'h0004_0000_0000_0000, 0, 1, 32'hFFFF_0000, 2'b10);
    chk("cnt_two", ovf_count, 2);
    // Clear in the same cycle as an overflowing handshake.
    dataIn = 64'h0000_0000_0009_0000; is_signed = 0; saturate = 1; valid_in = 1;
    @(posedge clk); #1 valid_in = 0;
    @(posedge clk); #1;
    chk("clr_hs_valid", valid_out, 1);
    ovf_clear = 1;
    @(posedge clk); #1 ovf_clear = 0;
    chk("clr_priority", ovf_count, 0);

    // Reset mid-stream.
    for (int i = 0; i < 4; i++) pushWord(64'h0000_0000_0010_0000, 0, 1);
    chk("pre_rst_valid", valid_out, 1);
    rst = 0;
    #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_count", ovf_count, 0);
    @(posedge clk); #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_idle", valid_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
